// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit carry-lookahead
// slice for NIB consecutive cycles, least significant nibble first.
//
// Handshake contract: start is a request that is honoured only in IDLE or
// DONE (start in RUN is ignored). When it is accepted, a, b and cin are
// captured on that edge. busy is high for the NIB cycles of RUN. done is
// high for exactly one cycle, and during that cycle sum/cout hold the
// result. sum/cout stay stable until the next accepted start.

// carry_look: 4-bit carry-lookahead slice; all carries derived from p/g terms.
module carry_look (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
    s    = p ^ c[3:0];
    c4   = c[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [3:0] slice_s;
  logic       slice_c4;
  logic       accept;
  logic       last_nib;
  logic       in_run;

  assign in_run   = (state == S_RUN);
  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_nib = in_run && (cnt == LAST_NIB);

  // The only adder hardware: fed exclusively from registers, never from ports.
  carry_look u_slice (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .c0 (carry),
    .s  (slice_s),
    .c4 (slice_c4)
  );

  // Control FSM with registered busy/done/cout; reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (last_nib) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= slice_c4;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture, then one nibble per RUN edge shifted through the slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (in_run) begin
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      sum   <= {slice_s, sum[WIDTH-1:4]};
      carry <= slice_c4;
      // Hold on the final nibble so the counter never wraps inside RUN.
      if (!last_nib) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vectors plus random traffic,
// results compared by a done-driven monitor against an expected queue.
module tb_nibble_serial_adder;

  localparam int W   = 32;
  localparam int NIB = W / 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic [W:0] exp_q[$];

  int total;
  int bad;
  int done_cnt;
  logic prev_done;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Clock: 100 ns period, so the slice has ample settle time.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  initial begin
    prev_done = 1'b0;
    done_cnt  = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("done_not_consecutive", {63'd0, prev_done}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("result", {31'd0, cout, sum}, {31'd0, e});
        end
      end
      prev_done = done;
    end
  end

  // Called at a negedge: request an add and push its hand or model result.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic [W:0] exp, input bit hold);
    start = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
    end
  endtask

  // Wait (bounded) for done; returns cycles since start edge and busy count.
  task automatic wait_done(output int lat, output int busy_cycles,
                           input bit scramble);
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      if (scramble) begin
        a = $urandom();
        b = $urandom();
        cin = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      check("done_timeout", 64'd0, 64'd1);
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int bc;
    int gap;
    int pre;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_sum", {32'd0, sum}, 64'd0);
    check("reset_cout", {63'd0, cout}, 64'd0);
    @(negedge clk);

    // Simple add: latency and busy length.
    issue(32'h0000_0005, 32'h0000_0003, 1'b0, 33'h0_0000_0008, 1'b0);
    wait_done(lat, bc, 1'b0);
    check("latency", 64'(lat), 64'd9);
    check("busy_cycles", 64'(bc), 64'd8);
    check("busy_low_at_done", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("done_single_pulse", {63'd0, done}, 64'd0);
    check("sum_held", {32'd0, sum}, 64'h0000_0008);

    // Full carry ripple.
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000, 1'b0);
    wait_done(lat, bc, 1'b0);
    @(negedge clk);

    // Overflow, start held high and operands scrambled during RUN.
    issue(32'h8765_4321, 32'h89AB_CDEF, 1'b0, 33'h1_1111_1110, 1'b1);
    wait_done(lat, bc, 1'b1);
    check("hold_latency", 64'(lat), 64'd9);
    @(negedge clk);
    @(negedge clk);

    // Back-to-back: second start placed in the DONE cycle.
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, 1'b0);
    wait_done(lat, bc, 1'b0);
    issue(32'h1234_5678, 32'h1111_1111, 1'b1, 33'h0_2345_678A, 1'b0);
    wait_done(lat, bc, 1'b0);
    check("b2b_latency", 64'(lat), 64'd9);
    @(negedge clk);

    // Reset asserted at the 4th RUN edge aborts the add.
    issue(32'h0000_1234, 32'h0000_4321, 1'b0, 33'h0_0000_5555, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_sum", {32'd0, sum}, 64'd0);
    check("abort_cout", {63'd0, cout}, 64'd0);
    pre = done_cnt;
    repeat (15) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(pre));
    issue(32'h0000_0001, 32'h0000_0001, 1'b0, 33'h0_0000_0002, 1'b0);
    wait_done(lat, bc, 1'b0);
    @(negedge clk);

    // Random traffic with random gaps (gap 0 means back-to-back).
    for (int i = 0; i < 500; i++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'd0, rc}, 1'b0);
      wait_done(lat, bc, 1'b0);
      check("rand_latency", 64'(lat), 64'(NIB + 1));
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Area-reduced WIDTH-bit adder built around one 4-bit carry-lookahead slice (carry_look), instantiated once and reused every cycle.
- Sits directly upstream of the slice and consumes its output. Each cycle it feeds one operand nibble plus the registered carry, then collects the slice's sum nibble and carry-out.
- Provides the serial-adder comparison point for the 32-bit fast-adder set.
- Start/done handshake to the surrounding test or datapath logic.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, nibble count (derived, not overridable).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  final carry-out; held with sum.

Behaviour:
- Reset values (rst high at a rising edge): state IDLE, busy=0, done=0, sum=0, cout=0, nibble counter=0, carry register=0, operand shift registers=0.
- rst has priority over everything, including an accepted start in the same cycle.
- Reset in RUN aborts the operation: no done pulse, sum=0.
- States:
  - IDLE: start=1 captures a, b and cin, clears the counter, and moves to RUN. start=0 stays in IDLE.
  - RUN: each edge does the following:
    - drives slice a/b with the low nibble of the A/B shift registers and slice c0 with the carry register;
    - shifts the slice sum nibble into the top of the sum shift register (sum shifts right by 4);
    - loads the slice cout into the carry register;
    - shifts the A/B registers right by 4 and increments the counter.
  - RUN → DONE: on the edge that processes nibble NIB-1. On that edge cout is loaded with the slice carry-out.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted (back-to-back) and moves to RUN. Otherwise move to IDLE.
- start in RUN is ignored. Operand changes after capture have no effect.
- Latency: start sampled at edge k, then done high during the cycle after edge k+NIB (8 edges for WIDTH=32). Throughput is one add per NIB+1 cycles when back-to-back.
- Nibble order is LSB first; nibble i is complete after RUN edge i.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- sum and cout are registered outputs. They are not guaranteed during RUN, because the partial shift contents are visible. They are only valid from done until the next accepted start.
- Timing:
  - The slice is gate-delayed; slice outputs settle within 60 ns of input change.
  - The simulation clock period must be ≥100 ns.
  - Slice inputs come only from registers, so there is no combinational path from ports to the slice.
- Counter width is clog2(NIB). It must not wrap while in RUN, and is cleared on every accepted start.

Test Plan:
- Reset, then a=32'h0000_0005, b=32'h0000_0003, cin=0, start one cycle → done 9 cycles after the start edge, sum=32'h0000_0008, cout=0, busy high for exactly 8 cycles.
- Full carry ripple across all nibbles: a=32'hFFFF_FFFF, b=32'h0000_0000, cin=1 → sum=32'h0000_0000, cout=1.
- Overflow with mixed nibbles: a=32'h8765_4321, b=32'h89AB_CDEF, cin=0 → sum=32'h1111_1110, cout=1. Hold start high throughout RUN with different a/b and confirm the result is unchanged.
- Back-to-back: start asserted in the DONE cycle with a=32'h1234_5678, b=32'h1111_1111, cin=1 → the second done arrives 9 cycles later with sum=32'h2345_678A, cout=0. The first result is correct at its done pulse.
- Reset mid-op: rst high at the 4th RUN edge → the next cycle has busy=0, done=0, sum=0, cout=0, and no done pulse ever. A following start with a=1, b=1 yields sum=2.
- Random: 500 random a/b/cin with random idle gaps, checked against a behavioural a+b+cin model at each done. Assert done is never high for 2 consecutive cycles.
